// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline memory-port arbiter: default widths,
// opcode constants and arbiter FSM state encodings.
package mips_pkg;

  localparam int MIPS_ADDR_W = 32;
  localparam int MIPS_DATA_W = 32;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT_IF = 2'd1;
  localparam logic [1:0] ST_GRANT_DM = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // True when the state is one of the two grant states (an access is on the bus)
  function automatic logic is_grant_state(input logic [1:0] st);
    return (st == ST_GRANT_IF) || (st == ST_GRANT_DM);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM
// stage. Each access is a registered req/ack handshake; the winner gets its
// read data with a one-cycle valid pulse, and stalls are raised while a
// stage's request is outstanding. A wait counter aborts accesses the memory
// never acknowledges; a starvation counter lets fetch through after a run of
// data grants.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = MIPS_ADDR_W,
  parameter int DATA_W     = MIPS_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [7:0]      WAIT_LIM   = 8'(TIMEOUT);

  logic [1:0]      state_r;
  logic [1:0]      state_next_s;
  logic [SC_W-1:0] starve_cnt_r;
  logic [7:0]      wait_cnt_r;

  logic starve_hit_s;
  logic grant_if_s;
  logic grant_dm_s;
  logic in_grant_s;
  logic ack_s;
  logic timeout_s;
  logic finish_s;

  // Arbitration decision and end-of-access detection
  always_comb begin
    grant_if_s   = 1'b0;
    grant_dm_s   = 1'b0;
    starve_hit_s = (starve_cnt_r == STARVE_LIM) && if_req;
    in_grant_s   = is_grant_state(state_r);
    if (state_r == ST_IDLE) begin
      if (dm_req && !starve_hit_s) begin
        grant_dm_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_dm_s = 1'b0;
        grant_if_s = 1'b0;
      end
    end else begin
      grant_dm_s = 1'b0;
      grant_if_s = 1'b0;
    end
    // An ack only counts while an access is actually on the bus
    ack_s     = in_grant_s && mem_ack;
    timeout_s = in_grant_s && !mem_ack && (wait_cnt_r == WAIT_LIM);
    finish_s  = ack_s || timeout_s;
  end

  // Next-state logic for the access sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_dm_s) begin
          state_next_s = ST_GRANT_DM;
        end else if (grant_if_s) begin
          state_next_s = ST_GRANT_IF;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GRANT_IF, ST_GRANT_DM: begin
        if (finish_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and memory-side request/address/data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_r <= state_next_s;
      if (grant_dm_s) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_if_s) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (finish_s) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  // Per-requester read data and one-cycle retire pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= finish_s && (state_r == ST_GRANT_IF);
      dm_valid <= finish_s && (state_r == ST_GRANT_DM);
      if (state_r == ST_GRANT_IF) begin
        if (ack_s) begin
          if_rdata <= mem_rdata;
        end else if (timeout_s) begin
          if_rdata <= '0;
        end
      end else if (state_r == ST_GRANT_DM) begin
        // Stores leave the last load result in place
        if (ack_s && !mem_we) begin
          dm_rdata <= mem_rdata;
        end else if (timeout_s) begin
          dm_rdata <= '0;
        end
      end
    end
  end

  // Wait counter: cycles spent in a grant state, cleared outside them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 8'd0;
    end else if (in_grant_s && !finish_s) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // Starvation counter: data grants taken while fetch was waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= '0;
    end else if (grant_if_s) begin
      starve_cnt_r <= '0;
    end else if (grant_dm_s && if_req && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + SC_W'(1);
    end
  end

  // Sticky record that some access was abandoned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (timeout_s) begin
      err_timeout <= 1'b1;
    end
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule
